// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared definitions for the LED sequencer: the FSM state
//               encoding and the default parameter values.
//               Build option: LED_SEQUENCER_DEBOUNCE_EN (used by sw_debounce).
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  // Sequencer states; the encoding is fixed so it can be probed externally
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    BACK = 2'd2
  } led_state_e;

  // Default parameter values shared by the sequencer and its debouncer
  localparam int unsigned LED_NLEDS_DEF    = 8;
  localparam int unsigned LED_CLK_DIV_DEF  = 4;
  localparam int unsigned LED_DEBOUNCE_DEF = 3;

  // Number of clock cycles taken by one complete forward/back sweep
  function automatic int unsigned led_sweep_cycles(input int unsigned nleds,
                                                   input int unsigned clk_div);
    return (2 * nleds - 2) * clk_div;
  endfunction

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_sequencer_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : Two-flop synchronizer for the raw switch level followed by an
//               optional debouncer. When LED_SEQUENCER_DEBOUNCE_EN is defined
//               the stable level only toggles after the synchronized level
//               has disagreed with it for DEBOUNCE consecutive edges; when it
//               is undefined the synchronized level is passed straight out.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce
  import led_pkg::*;
`ifdef LED_SEQUENCER_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE = LED_DEBOUNCE_DEF
)
`endif
(
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_sw,
  output logic o_sw_stable
);

  logic sync1_q;
  logic sync2_q;

  // Bring the asynchronous switch level into the clock domain
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_sw;
      sync2_q <= sync1_q;
    end
  end

`ifdef LED_SEQUENCER_DEBOUNCE_EN

  // DEBOUNCE is at most 255, so the run length always fits in 8 bits
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       stable_q;
  logic       stable_d;

  // Count consecutive disagreements; any agreement restarts the count
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign o_sw_stable = stable_q;

`else

  assign o_sw_stable = sync2_q;

`endif

endmodule : sw_debounce
`default_nettype wire

// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_sequencer
// Description : "Knight rider" LED sweeper. A rising switch level starts a
//               sweep that walks a single lit LED from position 0 up to
//               NLEDS-1 and back down to 1, holding each position CLK_DIV
//               cycles. At the end of a sweep the switch level decides
//               whether to sweep again or go idle.
//               Build option: LED_SEQUENCER_DEBOUNCE_EN enables the switch
//               debouncer inside sw_debounce.
// Revision    : 1.0 - initial release
// ============================================================================
module led_sequencer
  import led_pkg::*;
#(
  parameter int unsigned NLEDS    = LED_NLEDS_DEF,
  parameter int unsigned CLK_DIV  = LED_CLK_DIV_DEF,
  parameter int unsigned DEBOUNCE = LED_DEBOUNCE_DEF
)(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_sw,
  output logic [NLEDS-1:0] o_led,
  output logic             o_busy
);

  localparam int unsigned POS_W   = $clog2(NLEDS);
  localparam int unsigned PRESC_W = $clog2(CLK_DIV + 1);

  localparam logic [POS_W-1:0]   POS_FIRST  = '0;
  localparam logic [POS_W-1:0]   POS_ONE    = POS_W'(1);
  localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(NLEDS - 1);
  localparam logic [POS_W-1:0]   POS_TURN   = POS_W'(NLEDS - 2);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

  // Reject illegal configurations at elaboration time
  if (NLEDS < 2 || NLEDS > 32) begin : g_bad_nleds
    $error("led_sequencer: NLEDS must be in 2..32");
  end
  if (CLK_DIV < 1 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("led_sequencer: CLK_DIV must be in 1..65535");
  end
  if (DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_debounce
    $error("led_sequencer: DEBOUNCE must be in 1..255");
  end

  logic sw_stable;

`ifdef LED_SEQUENCER_DEBOUNCE_EN
  sw_debounce #(
    .DEBOUNCE    (DEBOUNCE)
  ) u_sw_debounce (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_sw        (i_sw),
    .o_sw_stable (sw_stable)
  );
`else
  sw_debounce u_sw_debounce (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_sw        (i_sw),
    .o_sw_stable (sw_stable)
  );
`endif

  led_state_e           state_q;
  led_state_e           state_d;
  logic [POS_W-1:0]     pos_q;
  logic [POS_W-1:0]     pos_d;
  logic [PRESC_W-1:0]   presc_q;
  logic [PRESC_W-1:0]   presc_d;
  logic [NLEDS-1:0]     led_q;
  logic [NLEDS-1:0]     led_d;
  logic                 busy_q;
  logic                 busy_d;
  logic                 sw_prev_q;
  logic                 sw_rise;
  logic                 presc_expired;
  logic                 sweep_done;

  // A start request is a 0->1 change of the debounced level
  assign sw_rise       = sw_stable & ~sw_prev_q;
  assign presc_expired = (presc_q == PRESC_LAST);

  // Next-state, position and prescale computation for the sweep
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    presc_d    = presc_q;
    sweep_done = 1'b0;

    case (state_q)
      IDLE: begin
        pos_d   = POS_FIRST;
        presc_d = '0;
        // Start only on a fresh rise; a level that is merely high does not
        if (sw_rise) begin
          state_d = FWD;
        end
      end

      FWD: begin
        if (!presc_expired) begin
          presc_d = presc_q + PRESC_W'(1);
        end else begin
          presc_d = '0;
          if (pos_q == POS_LAST) begin
            // With two LEDs there is no interior position to walk back over
            if (NLEDS == 2) begin
              sweep_done = 1'b1;
            end else begin
              state_d = BACK;
              pos_d   = POS_TURN;
            end
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
      end

      BACK: begin
        if (!presc_expired) begin
          presc_d = presc_q + PRESC_W'(1);
        end else begin
          presc_d = '0;
          if (pos_q == POS_ONE) begin
            sweep_done = 1'b1;
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        pos_d   = POS_FIRST;
        presc_d = '0;
      end
    endcase

    // The switch level is only consulted once a sweep has fully finished
    if (sweep_done) begin
      pos_d   = POS_FIRST;
      presc_d = '0;
      state_d = sw_stable ? FWD : IDLE;
    end

    busy_d = (state_d != IDLE);
    led_d  = busy_d ? (NLEDS'(1) << pos_d) : '0;
  end

  // Sequencer state and registered LED/busy outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      presc_q   <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
      sw_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      presc_q   <= presc_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      sw_prev_q <= sw_stable;
    end
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;

endmodule : led_sequencer
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_sequencer
// Description : Self-checking bench for led_sequencer. Every clock edge the
//               stimulus process advances a reference model (switch history
//               window + sweep pattern table) and queues the expected LED and
//               busy values; a monitor pops and compares one entry per cycle.
//               Follows LED_SEQUENCER_DEBOUNCE_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_sequencer;

  localparam int NLEDS    = 4;
  localparam int CLK_DIV  = 2;
  localparam int DEBOUNCE = 3;
  localparam int NPOS     = 2 * NLEDS - 2;
  localparam int SWEEP    = NPOS * CLK_DIV;
  localparam int HIST     = 24;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             sw    = 1'b0;
  logic [NLEDS-1:0] led;
  logic             busy;

  led_sequencer #(
    .NLEDS     (NLEDS),
    .CLK_DIV   (CLK_DIV),
    .DEBOUNCE  (DEBOUNCE)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_sw      (sw),
    .o_led     (led),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NLEDS-1:0] led;
    logic             busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: LED index visited at each hold step of one sweep
  int pattern [NPOS];
  bit s_h[$];     // raw switch samples, newest first
  bit sync_h[$];  // synchronized level after each edge, newest first
  bit stab_h[$];  // stable level after each edge, newest first
  bit m_busy;
  int m_t;        // cycle index inside the current sweep

  task automatic model_edge(input bit sw_v, input bit rst_v);
    bit   new_sync, a1, a2, new_stab;
    bit   all_diff;
    exp_t e;
    if (!rst_v) begin
      s_h.delete();
      sync_h.delete();
      stab_h.delete();
      m_busy = 1'b0;
      m_t    = 0;
    end else begin
      new_sync = (s_h.size() > 0) ? s_h[0] : 1'b0;
      a1 = (stab_h.size() > 0) ? stab_h[0] : 1'b0;
      a2 = (stab_h.size() > 1) ? stab_h[1] : 1'b0;
`ifdef LED_SEQUENCER_DEBOUNCE_EN
      // Toggle once the last DEBOUNCE synchronized samples all disagree
      all_diff = (sync_h.size() >= DEBOUNCE);
      for (int k = 0; k < DEBOUNCE; k++)
        if (k < sync_h.size() && sync_h[k] == a1) all_diff = 1'b0;
      new_stab = all_diff ? ~a1 : a1;
`else
      all_diff = 1'b0;
      new_stab = new_sync;
`endif
      // Sweep progression uses the stable level seen before this edge
      if (m_busy) begin
        m_t++;
        if (m_t == SWEEP) begin
          m_t = 0;
          if (!a1) m_busy = 1'b0;
        end
      end else if (a1 && !a2) begin
        m_busy = 1'b1;
        m_t    = 0;
      end
      s_h.push_front(sw_v);
      sync_h.push_front(new_sync);
      stab_h.push_front(new_stab);
      if (s_h.size() > HIST)    void'(s_h.pop_back());
      if (sync_h.size() > HIST) void'(sync_h.pop_back());
      if (stab_h.size() > HIST) void'(stab_h.pop_back());
    end
    e.busy = m_busy;
    e.led  = m_busy ? (NLEDS'(1) << pattern[m_t / CLK_DIV]) : '0;
    exp_q.push_back(e);
  endtask

  // One clock cycle: change inputs after the falling edge, model the rise
  task automatic cyc(input bit sw_v, input bit rst_v);
    @(negedge clk);
    #1;
    sw    = sw_v;
    rst_n = rst_v;
    @(posedge clk);
    model_edge(sw_v, rst_v);
  endtask

  // Assert reset between edges and require the outputs to clear at once
  task automatic async_reset_check();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (led !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: led=%b busy=%b required led=%b busy=0",
               led, busy, {NLEDS{1'b0}});
    end
    @(posedge clk);
    model_edge(sw, 1'b0);
  endtask

  // Monitor: one expected entry per cycle, compared away from the rising edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      if (led !== mon_e.led || busy !== mon_e.busy) begin
        n_err++;
        $display("FAIL outputs @%0t: led=%b busy=%b required led=%b busy=%b",
                 $time, led, busy, mon_e.led, mon_e.busy);
      end
    end
  end

  initial begin
    for (int i = 0; i < NPOS; i++)
      pattern[i] = (i < NLEDS) ? i : (2 * NLEDS - 2 - i);

    // Reset held with the switch toggling
    for (int i = 0; i < 6; i++) cyc(1'($urandom_range(0, 1)), 1'b0);

    // Idle after release
    repeat (5) cyc(1'b0, 1'b1);

    // Short two-cycle pulse
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (SWEEP + 15) cyc(1'b0, 1'b1);

    // Switch held: repeated sweeps, then dropped at a random point
    repeat (3 * SWEEP + 10) cyc(1'b1, 1'b1);
    repeat ($urandom_range(0, SWEEP)) cyc(1'b1, 1'b1);
    repeat (SWEEP + 15) cyc(1'b0, 1'b1);

    // Held high with brief low glitches while busy
    for (int i = 0; i < 50; i++) cyc(1'((i % 7) != 3), 1'b1);

    // Mid-sweep reset, then release with the switch already high
    async_reset_check();
    cyc(1'b1, 1'b0);
    repeat (2 * SWEEP + 10) cyc(1'b1, 1'b1);
    repeat (SWEEP + 10) cyc(1'b0, 1'b1);

    // Random switch activity with random hold lengths
    for (int i = 0; i < 80; i++) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) cyc(v, 1'b1);
    end
    repeat (SWEEP + 20) cyc(1'b0, 1'b1);

    // Let the monitor consume the last expectation
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending=%0d required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_led_sequencer
`default_nettype wire
